// File: rtl/sm3_pkg.sv
// Shared types and constants for the SM3 message padder.
package sm3_pkg;

    typedef enum logic [1:0] {S_DATA, S_P80, S_ZERO, S_LEN} pad_st_t;

    localparam int SM3_BLK_BITS = 512;
    localparam int SM3_LEN_BITS = 64;

    // Number of set bits in a byte-valid vector (up to 8 lanes).
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sm3_pad_byte_merge.sv
// Combinational byte masking, 0x80 terminator insertion and byte-valid
// contiguity check for one message word (first byte in the MSBs).
module sm3_pad_byte_merge
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32
) (
    input  logic [INPT_DW-1:0]   d,
    input  logic [INPT_DW/8-1:0] vb,
    input  logic                 lst,
    output logic [INPT_DW-1:0]   word,
    output logic [3:0]           cnt,
    output logic                 full,
    output logic                 err
);
    localparam int NB = INPT_DW / 8;

    assign cnt  = popcount(8'(vb));
    assign full = (cnt == 4'(NB));

    // Mask invalid bytes, place 0x80 right after the valid bytes of a last word.
    always_comb begin
        word = {INPT_DW{1'b0}};
        err  = 1'b0;
        for (int j = 0; j < NB; j++) begin
            if (vb[NB-1-j]) begin
                word[INPT_DW-1-8*j -: 8] = d[INPT_DW-1-8*j -: 8];
            end else if (lst && (4'(j) == cnt)) begin
                word[INPT_DW-1-8*j -: 8] = 8'h80;
            end else begin
                word[INPT_DW-1-8*j -: 8] = 8'h00;
            end
        end
        // A valid byte must never follow an invalid one.
        for (int i = 0; i < NB - 1; i++) begin
            err = err | (vb[i] & ~vb[i+1]);
        end
        err = err | (~lst & (vb != {NB{1'b1}}));
    end

endmodule

// File: rtl/sm3_pad_core.sv
// SM3 message padder: streams message words through a single output register,
// then appends 0x80, zero fill and the 64-bit big-endian bit length.
module sm3_pad_core
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32,
    parameter int LEN_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INPT_DW-1:0]   msg_inpt_d_i,
    input  logic [INPT_DW/8-1:0] msg_inpt_vld_byte_i,
    input  logic                 msg_inpt_vld_i,
    input  logic                 msg_inpt_lst_i,
    output logic                 msg_inpt_rdy_o,
    input  logic                 pad_otpt_ena_i,
    output logic [INPT_DW-1:0]   pad_otpt_d_o,
    output logic                 pad_otpt_vld_o,
    output logic                 pad_otpt_blk_lst_o,
    output logic                 pad_otpt_lst_o,
    output logic                 pad_err_o
);
    localparam int WPB    = SM3_BLK_BITS / INPT_DW;
    localparam int LW     = SM3_LEN_BITS / INPT_DW;
    localparam int WIDX_W = $clog2(WPB);

    localparam logic [WIDX_W-1:0]  IDX_BLK_LAST  = WIDX_W'(WPB - 1);
    localparam logic [WIDX_W-1:0]  IDX_ZERO_LAST = WIDX_W'(WPB - LW - 1);
    localparam logic [WIDX_W-1:0]  IDX_LEN_FIRST = WIDX_W'(WPB - LW);
    localparam logic [INPT_DW-1:0] P80_WORD      = {8'h80, {(INPT_DW-8){1'b0}}};

    pad_st_t             st_r, st_s, route_st_s;
    logic                xblk_r, xblk_s, route_xblk_s;
    logic [WIDX_W-1:0]   widx_r, widx_s, lidx_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic [INPT_DW-1:0]  d_r, d_s, len_word_s;
    logic                vld_r, vld_s, blk_r, blk_s, lst_r, lst_s, err_r, err_s;
    logic                adv_s, load_s;
    logic [INPT_DW-1:0]  mrg_word_s;
    logic [3:0]          mrg_cnt_s;
    logic                mrg_full_s, mrg_err_s;
    logic [63:0]         len64_s, len_sh_s;

    sm3_pad_byte_merge #(.INPT_DW(INPT_DW)) u_merge (
        .d    (msg_inpt_d_i),
        .vb   (msg_inpt_vld_byte_i),
        .lst  (msg_inpt_lst_i),
        .word (mrg_word_s),
        .cnt  (mrg_cnt_s),
        .full (mrg_full_s),
        .err  (mrg_err_s)
    );

    assign adv_s          = ~vld_r | pad_otpt_ena_i;
    assign msg_inpt_rdy_o = (st_r == S_DATA) & adv_s;

    assign pad_otpt_d_o       = d_r;
    assign pad_otpt_vld_o     = vld_r;
    assign pad_otpt_blk_lst_o = blk_r;
    assign pad_otpt_lst_o     = lst_r;
    assign pad_err_o          = err_r;

    assign len64_s    = 64'(len_r);
    assign lidx_s     = widx_r - IDX_LEN_FIRST;
    assign len_sh_s   = len64_s << (INPT_DW * int'(lidx_s));
    assign len_word_s = len_sh_s[63 -: INPT_DW];

    // Where to go after the 0x80 word: straight to length, zero fill, or fill across a block.
    always_comb begin
        if (widx_r == IDX_ZERO_LAST) begin
            route_st_s   = S_LEN;
            route_xblk_s = 1'b0;
        end else if (widx_r < IDX_ZERO_LAST) begin
            route_st_s   = S_ZERO;
            route_xblk_s = 1'b0;
        end else begin
            route_st_s   = S_ZERO;
            route_xblk_s = (widx_r != IDX_BLK_LAST);
        end
    end

    // Next-state and output-register load logic.
    always_comb begin
        st_s   = st_r;
        xblk_s = xblk_r;
        widx_s = widx_r;
        len_s  = len_r;
        err_s  = err_r;
        d_s    = d_r;
        vld_s  = vld_r;
        blk_s  = blk_r;
        lst_s  = lst_r;
        load_s = 1'b0;
        if (adv_s) begin
            vld_s = 1'b0;
            blk_s = 1'b0;
            lst_s = 1'b0;
            case (st_r)
                S_DATA: begin
                    if (msg_inpt_vld_i) begin
                        load_s = 1'b1;
                        d_s    = mrg_word_s;
                        len_s  = len_r + LEN_W'({mrg_cnt_s, 3'b000});
                        err_s  = err_r | mrg_err_s;
                        if (!msg_inpt_lst_i) begin
                            st_s = S_DATA;
                        end else if (mrg_full_s) begin
                            st_s = S_P80;
                        end else begin
                            st_s   = route_st_s;
                            xblk_s = route_xblk_s;
                        end
                    end else begin
                        load_s = 1'b0;
                    end
                end
                S_P80: begin
                    load_s = 1'b1;
                    d_s    = P80_WORD;
                    st_s   = route_st_s;
                    xblk_s = route_xblk_s;
                end
                S_ZERO: begin
                    load_s = 1'b1;
                    d_s    = {INPT_DW{1'b0}};
                    if (xblk_r) begin
                        xblk_s = (widx_r != IDX_BLK_LAST);
                    end else if (widx_r == IDX_ZERO_LAST) begin
                        st_s = S_LEN;
                    end else begin
                        st_s = S_ZERO;
                    end
                end
                S_LEN: begin
                    load_s = 1'b1;
                    d_s    = len_word_s;
                    if (widx_r == IDX_BLK_LAST) begin
                        lst_s = 1'b1;
                        st_s  = S_DATA;
                        len_s = {LEN_W{1'b0}};
                    end else begin
                        st_s = S_LEN;
                    end
                end
                default: begin
                    st_s   = S_DATA;
                    xblk_s = 1'b0;
                end
            endcase
            if (load_s) begin
                vld_s  = 1'b1;
                blk_s  = (widx_r == IDX_BLK_LAST);
                widx_s = widx_r + WIDX_W'(1);
            end else begin
                widx_s = widx_r;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r   <= S_DATA;
            xblk_r <= 1'b0;
            widx_r <= {WIDX_W{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            err_r  <= 1'b0;
            d_r    <= {INPT_DW{1'b0}};
            vld_r  <= 1'b0;
            blk_r  <= 1'b0;
            lst_r  <= 1'b0;
        end else begin
            st_r   <= st_s;
            xblk_r <= xblk_s;
            widx_r <= widx_s;
            len_r  <= len_s;
            err_r  <= err_s;
            d_r    <= d_s;
            vld_r  <= vld_s;
            blk_r  <= blk_s;
            lst_r  <= lst_s;
        end
    end

endmodule

// File: tb/tb_sm3_pad_core.sv
// Directed bench for sm3_pad_core: 32-bit and 64-bit instances, hand-computed
// padded streams, stall stability, error flag and mid-message reset.
module tb_sm3_pad_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] d32;
    logic [3:0]  vb32;
    logic        vld32, lst32, ena32, rdy32, ovld32, oblk32, olst32, err32;
    logic [31:0] od32;
    logic [63:0] d64, od64;
    logic [7:0]  vb64;
    logic        vld64, lst64, ena64, rdy64, ovld64, oblk64, olst64, err64;

    sm3_pad_core #(.INPT_DW(32), .LEN_W(64)) dut32 (
        .clk(clk), .rst(rst),
        .msg_inpt_d_i(d32), .msg_inpt_vld_byte_i(vb32), .msg_inpt_vld_i(vld32),
        .msg_inpt_lst_i(lst32), .msg_inpt_rdy_o(rdy32), .pad_otpt_ena_i(ena32),
        .pad_otpt_d_o(od32), .pad_otpt_vld_o(ovld32), .pad_otpt_blk_lst_o(oblk32),
        .pad_otpt_lst_o(olst32), .pad_err_o(err32)
    );

    sm3_pad_core #(.INPT_DW(64), .LEN_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .msg_inpt_d_i(d64), .msg_inpt_vld_byte_i(vb64), .msg_inpt_vld_i(vld64),
        .msg_inpt_lst_i(lst64), .msg_inpt_rdy_o(rdy64), .pad_otpt_ena_i(ena64),
        .pad_otpt_d_o(od64), .pad_otpt_vld_o(ovld64), .pad_otpt_blk_lst_o(oblk64),
        .pad_otpt_lst_o(olst64), .pad_err_o(err64)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q_d32[$];
    logic [1:0]  q_f32[$];
    logic [63:0] q_d64[$];
    logic [1:0]  q_f64[$];
    int          lst_cnt32 = 0;
    int          lst_cnt64 = 0;
    logic        hold32 = 1'b0;
    logic [34:0] held32 = 35'd0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    logic [63:0] exp_q[$];
    logic        tog = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Capture transferred words of the 32-bit instance and watch stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                stall_seen++;
                if ({ovld32, oblk32, olst32, od32} !== held32) stall_bad++;
            end
            if (ovld32 && ena32) begin
                q_d32.push_back({32'h0, od32});
                q_f32.push_back({oblk32, olst32});
                if (olst32) lst_cnt32++;
            end
            hold32 = ovld32 && !ena32;
            held32 = {ovld32, oblk32, olst32, od32};
        end
    end

    // Capture transferred words of the 64-bit instance.
    always @(negedge clk) begin
        if (!rst && ovld64 && ena64) begin
            q_d64.push_back(od64);
            q_f64.push_back({oblk64, olst64});
            if (olst64) lst_cnt64++;
        end
    end

    function automatic logic [31:0] wd(input int i);
        return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    endfunction

    task automatic exp_zeros(input int n);
        repeat (n) exp_q.push_back(64'h0);
    endtask

    task automatic send32(input logic [31:0] d, input logic [3:0] vb, input logic lst);
        bit done;
        done = 1'b0;
        d32 = d; vb32 = vb; lst32 = lst; vld32 = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = rdy32;
            @(posedge clk);
            #1;
        end
        vld32 = 1'b0; lst32 = 1'b0;
        if (!done) check_val("send32 timeout", 64'd0, 64'd1);
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] vb, input logic lst);
        bit done;
        done = 1'b0;
        d64 = d; vb64 = vb; lst64 = lst; vld64 = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = rdy64;
            @(posedge clk);
            #1;
        end
        vld64 = 1'b0; lst64 = 1'b0;
        if (!done) check_val("send64 timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int start, input bit is64);
        for (int t = 0; t < 400 && (is64 ? lst_cnt64 : lst_cnt32) == start; t++) begin
            @(posedge clk);
            #1;
            if (tog) ena32 = ~ena32;
        end
        ena32 = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int base, input bit is64);
        int n, got, wpb;
        logic [63:0] od;
        logic [1:0]  of, ef;
        n   = exp_q.size();
        wpb = is64 ? 8 : 16;
        got = (is64 ? q_d64.size() : q_d32.size()) - base;
        check_val({tag, " words"}, 64'(got), 64'(n));
        for (int i = 0; i < n && i < got; i++) begin
            od = is64 ? q_d64[base+i] : q_d32[base+i];
            of = is64 ? q_f64[base+i] : q_f32[base+i];
            ef = {((i % wpb) == wpb - 1), (i == n - 1)};
            check_val($sformatf("%s d[%0d]", tag, i), od, exp_q[i]);
            check_val($sformatf("%s blk,lst[%0d]", tag, i), 64'(of), 64'(ef));
        end
    endtask

    task automatic run_abc(input string tag);
        int base, start;
        base = q_d32.size(); start = lst_cnt32;
        exp_q.delete();
        exp_q.push_back(64'h61626380);
        exp_zeros(14);
        exp_q.push_back(64'h18);
        send32(32'h61626300, 4'b1110, 1'b1);
        wait_done(start, 1'b0);
        check_stream(tag, base, 1'b0);
    endtask

    initial begin
        int base, start;
        logic [31:0] w;
        rst = 1'b1;
        d32 = 32'h0; vb32 = 4'h0; vld32 = 1'b0; lst32 = 1'b0; ena32 = 1'b1;
        d64 = 64'h0; vb64 = 8'h0; vld64 = 1'b0; lst64 = 1'b0; ena64 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst vld", {63'd0, ovld32}, 64'd0);
        check_val("rst d", {32'd0, od32}, 64'd0);
        check_val("rst flags", {61'd0, oblk32, olst32, err32}, 64'd0);
        check_val("rst rdy", {63'd0, rdy32}, 64'd1);
        check_val("rst vld64", {63'd0, ovld64}, 64'd0);

        // "abc": single block, zero fill, length 0x18
        run_abc("t1");

        // 56 bytes: 0x80 at word 14, fill spills into a second block
        base = q_d32.size(); start = lst_cnt32;
        exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back({32'h0, wd(i)});
        exp_q.push_back(64'h80000000);
        exp_zeros(16);
        exp_q.push_back(64'h1C0);
        for (int i = 0; i < 14; i++) send32(wd(i), 4'hF, i == 13);
        wait_done(start, 1'b0);
        check_stream("t2", base, 1'b0);

        // 54 bytes: 0x80 inside word 13, length follows immediately
        base = q_d32.size(); start = lst_cnt32;
        exp_q.delete();
        for (int i = 0; i < 13; i++) exp_q.push_back({32'h0, wd(i)});
        w = wd(13);
        exp_q.push_back({32'h0, w[31:16], 16'h8000});
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1B0);
        for (int i = 0; i < 14; i++) send32(wd(i), (i == 13) ? 4'b1100 : 4'hF, i == 13);
        wait_done(start, 1'b0);
        check_stream("t7", base, 1'b0);

        // 64 bytes: message ends on a block boundary, 0x80 opens a new block
        base = q_d32.size(); start = lst_cnt32;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({32'h0, wd(i)});
        exp_q.push_back(64'h80000000);
        exp_zeros(14);
        exp_q.push_back(64'h200);
        for (int i = 0; i < 16; i++) send32(wd(i), 4'hF, i == 15);
        wait_done(start, 1'b0);
        check_stream("t8", base, 1'b0);

        // 64-bit empty message
        base = q_d64.size(); start = lst_cnt64;
        exp_q.delete();
        exp_q.push_back(64'h8000000000000000);
        exp_zeros(7);
        send64(64'h1122334455667788, 8'h00, 1'b1);
        wait_done(start, 1'b1);
        check_stream("t3", base, 1'b1);

        // "abc" with downstream ready toggling
        tog = 1'b1;
        run_abc("t4");
        tog = 1'b0;
        check_val("t4 stall unstable", 64'(stall_bad), 64'd0);
        check_val("t4 stalls seen", {63'd0, stall_seen > 0}, 64'd1);

        // Non-contiguous byte valids on a non-last word
        send32(32'hAABBCCDD, 4'b1010, 1'b0);
        check_val("t5 err", {63'd0, err32}, 64'd1);
        check_val("t5 masked", {31'd0, ovld32, od32}, {31'd0, 1'b1, 32'hAA00CC00});
        repeat (3) @(posedge clk);
        #1;
        check_val("t5 err sticky", {63'd0, err32}, 64'd1);

        // Reset while zero filling, then a fresh message
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send32(32'h61626300, 4'b1110, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("t6 vld", {63'd0, ovld32}, 64'd0);
        check_val("t6 rdy", {63'd0, rdy32}, 64'd1);
        check_val("t6 err", {63'd0, err32}, 64'd0);
        run_abc("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
